// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the request arbiter
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;
  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

  localparam int ARB_MAX_N = 32;

  // OR-reduction encoder; exact for one-hot or zero inputs
  function automatic logic [4:0] onehot2idx(input logic [ARB_MAX_N-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner search descending from ptr with wrap
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] win,
  output logic [W-1:0] win_idx,
  output logic         found
);

  int k;

  always_comb begin
    win   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + N - i) % N;
      if (!found && req[k]) begin
        win[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign win_idx = W'(onehot2idx(ARB_MAX_N'(win)));

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way arbiter with registered locked grants
// Optional grant hold limit enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 64,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  arb_state_e   state, state_n;
  logic [N-1:0] gnt_n;
  logic [W-1:0] idx_n;
  logic [W-1:0] ptr, ptr_n, pick_ptr;
  logic [N-1:0] win;
  logic [W-1:0] win_idx;
  logic         found;
  logic         hold_expired;
  logic         release_now;

  // fixed priority is the same search started permanently at the top index
  assign pick_ptr = (MODE == int'(ARB_RR)) ? ptr : W'(N - 1);

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .win     (win),
    .win_idx (win_idx),
    .found   (found)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  assign hold_expired = (hold_cnt == HW'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  assign release_now = rel || !req[gnt_idx] || hold_expired;
  assign gnt_vld     = |gnt;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    ptr_n   = ptr;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_n = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (en && found) begin
          state_n = LOCKED;
          gnt_n   = win;
          idx_n   = win_idx;
          if (MODE == int'(ARB_RR)) begin
            ptr_n = (win_idx == '0) ? W'(N - 1) : win_idx - 1'b1;
          end
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_n = '0;
`endif
        end
      end
      LOCKED: begin
        if (release_now) begin
          state_n = IDLE;
          gnt_n   = '0;
          idx_n   = '0;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= W'(N - 1);
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      ptr     <= ptr_n;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= hold_cnt_n;
`endif
    end
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
Parametrised N-way request arbiter with registered, locked grants. It is the successor to the combinational fixed-priority encoder. It adds selectable round-robin fairness, grant hold until release, and an encoded grant index. It arbitrates MAC-side clients (TX queues, descriptor/DMA masters) onto one shared resource.

Parameters:
N, 4, number of requesters; legal range 2..32.
MODE, 1, 0 = fixed priority (highest index wins), 1 = round-robin.
MAX_HOLD, 64, maximum cycles a grant may be held; used only when ARB_HOLD_LIMIT_EN is defined; legal range >= 1.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous reset, active-high.
en  in  1  arbitration enable; when low, no new grant is issued.
req  in  N  request vector; bit i = requester i.
rel  in  1  release pulse from the owner of the current grant (last beat consumed).
gnt  out  N  one-hot grant, registered.
gnt_idx  out  $clog2(N)  binary index of the granted requester; valid only while gnt_vld=1.
gnt_vld  out  1  high while any grant is held (equals |gnt).

Behaviour:
- Reset (rst=1 at a clk edge): gnt=0, gnt_idx=0, gnt_vld=0, state=IDLE, ptr=N-1, hold counter=0. rst has priority over every other input.
- State machine has two states: IDLE and LOCKED.
- IDLE: if en=1 and |req=1, pick a winner. On the next edge, gnt=onehot(w), gnt_idx=w, gnt_vld=1, state goes to LOCKED. Request-to-grant latency is exactly 1 cycle. Otherwise stay in IDLE with outputs at 0.
- Winner selection in MODE=0: highest set index of req.
- Winner selection in MODE=1: search req starting at ptr and descending with wrap (ptr, ptr-1, ..., 0, N-1, ...). The first set bit wins. When a grant is issued to w, ptr <= (w==0) ? N-1 : w-1.
- LOCKED: gnt, gnt_idx and ptr are frozen. The grant ends when rel=1, or when req[gnt_idx]=0 (requester withdraws). On that edge: gnt=0, gnt_vld=0, state goes to IDLE.
- There is always at least one idle cycle between grants (gnt_vld low for 1 cycle). Re-arbitration happens in that IDLE cycle.
- rel while in IDLE is ignored. rel and withdrawal in the same cycle count as a single release.
- en=0 while LOCKED: the current grant persists until it is released. en only gates new grants.
- Requests that arrive while LOCKED wait; they are never dropped, because req is level-sensitive.
- gnt is always one-hot or zero, and gnt_idx always equals the encoded gnt whenever gnt_vld=1.
- MODE=1, every requester active continuously, N=4: grant order is 3,2,1,0,3,...
- ptr wraps from 0 to N-1.

Optional Feature:
Macro: ARB_HOLD_LIMIT_EN.
- Defined: a hold counter clears on grant issue and increments each LOCKED cycle. When it reaches MAX_HOLD-1 without a release, the next edge forces a release with the same effect as rel. Round-robin ptr has already advanced, so other requesters get service.
- Not defined: no counter; a grant is held indefinitely until rel or withdrawal. MAX_HOLD is ignored.

Decomposition:
- Package arb_pkg holds the arb_state_e enum {IDLE, LOCKED}, the arb_mode_e enum {ARB_FIXED=0, ARB_RR=1}, and the function onehot2idx.
- Sub-module rr_pick (combinational): inputs req[N], ptr; outputs the winner one-hot and index. It implements the rotate-and-priority search. MODE=0 drives ptr=N-1 constant.
- rr_arbiter holds the FSM, registers, ptr and the hold counter.

Test Plan:
- Reset: assert rst for 2 cycles with req=4'b1111 -> gnt=0, gnt_vld=0, gnt_idx=0 throughout; first grant appears the cycle after rst deasserts, gnt=4'b1000.
- RR fairness, N=4, MODE=1: req=1111 held, rel pulsed 1 cycle after each grant -> grant sequence idx 3,2,1,0,3, with exactly 1 idle cycle between grants.
- Fixed priority, MODE=0: req=0101 held with repeated rel -> gnt=0100 every time; requester 0 starves.
- Lock and withdrawal: grant idx 1 issued, then req[3] asserts (stays locked, gnt=0010); then req[1] drops -> next cycle gnt=0, following cycle gnt=1000.
- en gating: en=0 with req=0011 -> no grant; en drops while LOCKED -> grant held until rel, then no new grant while en=0.
- With ARB_HOLD_LIMIT_EN defined and MAX_HOLD=4: req=0011, no rel -> gnt=0010 held for 4 cycles, released, 1 idle cycle, then gnt=0001.
